// File: rtl/cv_ctrl_port.sv
// ColecoVision/Adam controller port responder: keypad/joystick byte mux and spinner interrupt.
// Spinner decode, pend/spin_dir state and int_n_o are built only when CV_CTRL_SPINNER_EN is defined.
module cv_ctrl_port (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ctrl_en_key_n_i,
    input  logic        ctrl_en_joy_n_i,
    input  logic        ctrl_r_n_i,
    input  logic        a1_i,
    input  logic [5:0]  p1_joy_i,
    input  logic [5:0]  p2_joy_i,
    input  logic [11:0] p1_keys_i,
    input  logic [11:0] p2_keys_i,
    input  logic [1:0]  p1_spin_i,
    input  logic [1:0]  p2_spin_i,
    output logic [7:0]  d_o,
    output logic        int_n_o
);

    logic             r_key_n;
    logic             r_joy_n;
    logic             r_a1;
    logic             r_mode_key;
    logic [1:0][5:0]  r_joy_m;
    logic [1:0][5:0]  r_joy_s;
    logic [1:0][11:0] r_keys_m;
    logic [1:0][11:0] r_keys_s;
    logic [7:0]       r_d;

    logic [5:0]       w_joy;
    logic [11:0]      w_keys;
    logic [3:0]       w_code;
    logic             w_dir;
    logic [7:0]       w_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_key_n  <= 1'b1;
            r_joy_n  <= 1'b1;
            r_a1     <= 1'b0;
            r_joy_m  <= '0;
            r_joy_s  <= '0;
            r_keys_m <= '0;
            r_keys_s <= '0;
            r_d      <= 8'hFF;
        end else begin
            r_key_n  <= ctrl_en_key_n_i;
            r_joy_n  <= ctrl_en_joy_n_i;
            r_a1     <= a1_i;
            r_joy_m  <= {p2_joy_i, p1_joy_i};
            r_joy_s  <= r_joy_m;
            r_keys_m <= {p2_keys_i, p1_keys_i};
            r_keys_s <= r_keys_m;
            r_d      <= w_d;
        end
    end

    // Level-sensitive mode select; keypad wins when both strobes are low.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mode_key <= 1'b0;
        end else if (!r_key_n) begin
            r_mode_key <= 1'b1;
        end else if (!r_joy_n) begin
            r_mode_key <= 1'b0;
        end
    end

    always_comb begin
        w_joy  = r_a1 ? r_joy_s[1] : r_joy_s[0];
        w_keys = r_a1 ? r_keys_s[1] : r_keys_s[0];
        // Lowest pressed key index wins.
        casez (w_keys)
            12'b???????????1: w_code = 4'hA;
            12'b??????????10: w_code = 4'hD;
            12'b?????????100: w_code = 4'h7;
            12'b????????1000: w_code = 4'hC;
            12'b???????10000: w_code = 4'h2;
            12'b??????100000: w_code = 4'h3;
            12'b?????1000000: w_code = 4'hE;
            12'b????10000000: w_code = 4'h5;
            12'b???100000000: w_code = 4'h1;
            12'b??1000000000: w_code = 4'hB;
            12'b?10000000000: w_code = 4'h9;
            12'b100000000000: w_code = 4'h6;
            default:          w_code = 4'hF;
        endcase
        if (r_mode_key) begin
            w_d = {1'b1, ~w_joy[5], 2'b11, w_code};
        end else begin
            w_d = {1'b1, ~w_joy[4], 1'b1, w_dir, ~w_joy[3:0]};
        end
    end

    assign d_o = r_d;

`ifdef CV_CTRL_SPINNER_EN
    logic            r_rd_n;
    logic            r_rd_n_prev;
    logic [1:0][1:0] r_spin_m;
    logic [1:0][1:0] r_spin_s;
    logic [1:0]      r_a_prev;
    logic [1:0]      r_pend;
    logic [1:0]      r_dir;
    logic            r_int_n;
    logic [1:0]      w_step;
    logic [1:0]      w_clr;

    always_comb begin
        for (int q = 0; q < 2; q++) begin
            w_step[q] = r_spin_s[q][0] & ~r_a_prev[q];
        end
        w_clr[0] = ~r_rd_n & r_rd_n_prev & ~r_a1;
        w_clr[1] = ~r_rd_n & r_rd_n_prev & r_a1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_n      <= 1'b1;
            r_rd_n_prev <= 1'b1;
            r_spin_m    <= '0;
            r_spin_s    <= '0;
            r_a_prev    <= '0;
            r_pend      <= '0;
            r_dir       <= '0;
            r_int_n     <= 1'b1;
        end else begin
            r_rd_n      <= ctrl_r_n_i;
            r_rd_n_prev <= r_rd_n;
            r_spin_m    <= {p2_spin_i, p1_spin_i};
            r_spin_s    <= r_spin_m;
            r_a_prev    <= {r_spin_s[1][0], r_spin_s[0][0]};
            // A new step outranks a read clear in the same cycle.
            for (int q = 0; q < 2; q++) begin
                if (w_step[q]) begin
                    r_pend[q] <= 1'b1;
                    r_dir[q]  <= r_spin_s[q][1];
                end else if (w_clr[q]) begin
                    r_pend[q] <= 1'b0;
                end
            end
            r_int_n <= ~|r_pend;
        end
    end

    assign w_dir   = r_dir[r_a1];
    assign int_n_o = r_int_n;
`else
    logic w_unused;
    assign w_unused = ^{ctrl_r_n_i, p1_spin_i, p2_spin_i};
    assign w_dir    = 1'b1;
    assign int_n_o  = 1'b1;
`endif

endmodule

// File: tb/tb_cv_ctrl_port.sv
// Bench for cv_ctrl_port: latency-based reference model checked every cycle plus literal checks.
module tb_cv_ctrl_port;

    localparam int MaxC = 4096;
`ifdef CV_CTRL_SPINNER_EN
    localparam bit SpinEn = 1'b1;
`else
    localparam bit SpinEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_n = 1'b1;
    logic        joy_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        a1 = 1'b0;
    logic [5:0]  j1 = '0;
    logic [5:0]  j2 = '0;
    logic [11:0] k1 = '0;
    logic [11:0] k2 = '0;
    logic [1:0]  sp1 = '0;
    logic [1:0]  sp2 = '0;
    logic [7:0]  d;
    logic        int_n;

    always #5 clk = ~clk;

    cv_ctrl_port dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ctrl_en_key_n_i (key_n),
        .ctrl_en_joy_n_i (joy_n),
        .ctrl_r_n_i      (rd_n),
        .a1_i            (a1),
        .p1_joy_i        (j1),
        .p2_joy_i        (j2),
        .p1_keys_i       (k1),
        .p2_keys_i       (k2),
        .p1_spin_i       (sp1),
        .p2_spin_i       (sp2),
        .d_o             (d),
        .int_n_o         (int_n)
    );

    typedef struct packed {
        logic        rst;
        logic        key_n;
        logic        joy_n;
        logic        rd_n;
        logic        a1;
        logic [5:0]  j1;
        logic [5:0]  j2;
        logic [11:0] k1;
        logic [11:0] k2;
        logic [1:0]  sp1;
        logic [1:0]  sp2;
    } smp_t;

    smp_t       hist   [MaxC];
    logic       m_key  [MaxC];
    logic [1:0] m_pend [MaxC];
    logic [1:0] m_dir  [MaxC];
    logic [7:0] e_d    [MaxC];
    logic       e_int  [MaxC];
    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Inputs seen at edge j; edges under reset look like an idle bus.
    function automatic smp_t smp(input int j);
        smp_t s;
        s = '0;
        s.key_n = 1'b1;
        s.joy_n = 1'b1;
        s.rd_n  = 1'b1;
        if (j >= 0 && !hist[j].rst) s = hist[j];
        return s;
    endfunction

    function automatic logic [3:0] key_code(input logic [11:0] k);
        logic [47:0] tbl;
        tbl = 48'h69B15E32C7DA;  // nibble i = code of key bit i
        for (int i = 0; i < 12; i++) begin
            if (k[i]) return tbl[4*i +: 4];
        end
        return 4'hF;
    endfunction

    function automatic logic [7:0] cv_byte(input logic key, input logic [5:0] joy,
                                           input logic [11:0] keys, input logic dir);
        if (key) return {1'b1, ~joy[5], 2'b11, key_code(keys)};
        return {1'b1, ~joy[4], 1'b1, (SpinEn ? dir : 1'b1), ~joy[3:0]};
    endfunction

    // Expected outputs after edge j from inputs seen at edges j-1 (registered) and j-2 (synced).
    always @(posedge clk) begin : model
        smp_t       s1, s2, s3;
        logic       pk, p;
        logic [1:0] pp, pd;
        if (cyc >= MaxC) begin
            $display("FAIL model_budget: got %0d cycles, expected < %0d", cyc, MaxC);
            $fatal(1);
        end
        hist[cyc].rst   = ~reset_n;
        hist[cyc].key_n = key_n;
        hist[cyc].joy_n = joy_n;
        hist[cyc].rd_n  = rd_n;
        hist[cyc].a1    = a1;
        hist[cyc].j1    = j1;
        hist[cyc].j2    = j2;
        hist[cyc].k1    = k1;
        hist[cyc].k2    = k2;
        hist[cyc].sp1   = sp1;
        hist[cyc].sp2   = sp2;
        if (hist[cyc].rst || cyc == 0) begin
            m_key[cyc]  = 1'b0;
            m_pend[cyc] = '0;
            m_dir[cyc]  = '0;
            e_d[cyc]    = 8'hFF;
            e_int[cyc]  = 1'b1;
        end else begin
            s1 = smp(cyc - 1);
            s2 = smp(cyc - 2);
            s3 = smp(cyc - 3);
            pk = m_key[cyc-1];
            pp = m_pend[cyc-1];
            pd = m_dir[cyc-1];
            p  = s1.a1;
            e_d[cyc]   = cv_byte(pk, p ? s2.j2 : s2.j1, p ? s2.k2 : s2.k1, pd[p]);
            e_int[cyc] = SpinEn ? ~|pp : 1'b1;
            m_key[cyc] = !s1.key_n ? 1'b1 : (!s1.joy_n ? 1'b0 : pk);
            if (!s1.rd_n && s2.rd_n) pp[p] = 1'b0;
            if (s2.sp1[0] && !s3.sp1[0]) begin
                pp[0] = 1'b1;
                pd[0] = s2.sp1[1];
            end
            if (s2.sp2[0] && !s3.sp2[0]) begin
                pp[1] = 1'b1;
                pd[1] = s2.sp2[1];
            end
            m_pend[cyc] = pp;
            m_dir[cyc]  = pd;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        logic [7:0] ed;
        logic       ei;
        if (cyc > 0) begin
            if (!reset_n) begin
                ed = 8'hFF;
                ei = 1'b1;
            end else begin
                ed = e_d[cyc-1];
                ei = e_int[cyc-1];
            end
            check("cyc_d_o", d, ed);
            check("cyc_int_n", {7'd0, int_n}, {7'd0, ei});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_key();
        key_n = 1'b0;
        step(1);
        key_n = 1'b1;
    endtask

    task automatic pulse_joy();
        joy_n = 1'b0;
        step(1);
        joy_n = 1'b1;
    endtask

    initial begin
        step(3);
        reset_n = 1'b1;
        step(5);
        check("idle_joy", d, SpinEn ? 8'hEF : 8'hFF);
        check("idle_int", {7'd0, int_n}, 8'h01);

        k1 = 12'h020;
        j1 = 6'h20;
        pulse_key();
        step(3);
        check("key5_fire_r", d, 8'hB3);
        k1 = 12'h024;
        step(3);
        check("key2_priority", d, 8'hB7);
        k1 = '0;
        j1 = '0;
        step(3);
        check("key_release", d, 8'hFF);

        j2 = 6'b011001;
        a1 = 1'b1;
        pulse_joy();
        step(3);
        check("p2_joy", d, SpinEn ? 8'hA6 : 8'hB6);
        a1 = 1'b0;
        step(2);
        check("a1_latency", d, SpinEn ? 8'hEF : 8'hFF);

        j2 = '0;
        j1 = 6'h10;
        key_n = 1'b0;
        joy_n = 1'b0;
        step(1);
        key_n = 1'b1;
        joy_n = 1'b1;
        step(3);
        check("both_strobes_key", d, 8'hFF);
        j1 = '0;

        a1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            k2 = 12'(1 << i);
            k1 = 12'(1 << (11 - i));
            step(3);
        end
        k2 = 12'hC00;
        step(3);
        check("star_over_hash", d, 8'hF9);
        k2 = 12'h800;
        step(3);
        check("hash", d, 8'hF6);
        k2 = 12'h300;
        step(3);
        check("key8_over_key9", d, 8'hF1);
        k1 = '0;
        k2 = '0;

        pulse_joy();
        a1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            j1 = (i == 6) ? 6'h3F : 6'(1 << i);
            j2 = ~j1;
            step(3);
        end
        j1 = '0;
        j2 = '0;
        step(3);

        sp1 = 2'b10;
        step(3);
        sp1 = 2'b11;
        step(3);
        check("int_before_step", {7'd0, int_n}, 8'h01);
        step(1);
        check("int_after_step", {7'd0, int_n}, SpinEn ? 8'h00 : 8'h01);
        check("spin_dir_p1", d, 8'hFF);
        a1 = 1'b1;
        rd_n = 1'b0;
        step(1);
        rd_n = 1'b1;
        step(4);
        check("read_other_player", {7'd0, int_n}, SpinEn ? 8'h00 : 8'h01);
        a1 = 1'b0;
        step(2);
        rd_n = 1'b0;
        step(1);
        rd_n = 1'b1;
        step(1);
        check("clear_lat2", {7'd0, int_n}, SpinEn ? 8'h00 : 8'h01);
        step(1);
        check("clear_lat3", {7'd0, int_n}, 8'h01);

        sp1 = 2'b10;
        step(3);
        sp1 = 2'b11;
        step(6);
        sp1 = 2'b10;
        step(3);
        sp1 = 2'b11;
        step(1);
        rd_n = 1'b0;
        step(1);
        rd_n = 1'b1;
        step(4);
        check("step_beats_clear", {7'd0, int_n}, SpinEn ? 8'h00 : 8'h01);

        sp1 = 2'b00;
        step(5);
        k1 = 12'h001;
        pulse_key();
        step(3);
        check("key_before_reset", d, 8'hFA);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("reset_int", {7'd0, int_n}, 8'h01);
        check("reset_d", d, 8'hFF);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        step(4);
        check("mode_joy_after_reset", d, SpinEn ? 8'hEF : 8'hFF);
        k1 = '0;

        sp2 = 2'b01;
        step(4);
        check("p2_step_int", {7'd0, int_n}, SpinEn ? 8'h00 : 8'h01);
        a1 = 1'b1;
        rd_n = 1'b0;
        step(1);
        rd_n = 1'b1;
        step(5);
        check("p2_clear", {7'd0, int_n}, 8'h01);
        sp2 = '0;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
